chain_delay_meter: RTL and testbench



---
 rtl/chain_delay_meter.sv | 182 ++++++++++++++++++
 tb/tb_chain_delay_meter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_delay_meter.sv
// Measurement stage for the inverter-chain delay sensor: launches edges into the chain,
// times the synchronised response in clock cycles and averages over 2^AVG_LOG2 launches.
module chain_delay_meter #(
    parameter int CNT_W          = 16,
    parameter int AVG_LOG2       = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      chain_en,
    output logic                      chain_in,
    input  logic                      chain_out,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          delay_cycles,
    output logic [CNT_W+AVG_LOG2-1:0] delay_sum
);

    localparam int SUM_W  = CNT_W + AVG_LOG2;
    localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'((2 ** AVG_LOG2) - 1);
    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        MEASURE,
        RECOVER,
        FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SUM_W-1:0]       acc_q, acc_d;
    logic                   base_q, base_d;
    logic                   en_q, en_d;
    logic                   in_q, in_d;
    logic                   terr_q, terr_d;
    logic [CNT_W-1:0]       dly_q, dly_d;
    logic [SUM_W-1:0]       sum_q, sum_d;

    assign synced       = sync_q[SYNC_STAGES-1];
    assign chain_en     = en_q;
    assign chain_in     = in_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FINISH);
    assign timeout_err  = terr_q;
    assign delay_cycles = dly_q;
    assign delay_sum    = sum_q;

    // chain_in/chain_en are registered, so the edge reaches the chain one cycle after LAUNCH;
    // that cycle is the first MEASURE cycle, where the counter reads 0.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        base_d  = base_q;
        en_d    = en_q;
        in_d    = in_q;
        terr_d  = terr_q;
        dly_d   = dly_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                in_d   = 1'b0;
                wait_d = '0;
                if (start) begin
                    terr_d  = 1'b0;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                en_d = 1'b1;
                in_d = 1'b0;
                if (wait_q == SETTLE_LAST) begin
                    base_d  = synced;
                    wait_d  = '0;
                    state_d = LAUNCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            LAUNCH: begin
                en_d    = 1'b1;
                in_d    = 1'b1;
                cnt_d   = '0;
                state_d = MEASURE;
            end
            MEASURE: begin
                en_d = 1'b1;
                in_d = 1'b1;
                if (synced != base_q) begin
                    dly_d   = cnt_q;
                    acc_d   = acc_q + SUM_W'(cnt_q);
                    wait_d  = '0;
                    state_d = RECOVER;
                end else if (cnt_q == TIMEOUT_C) begin
                    terr_d  = 1'b1;
                    dly_d   = TIMEOUT_C;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                en_d = 1'b1;
                in_d = 1'b0;
                if (wait_q == SETTLE_LAST) begin
                    wait_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LAUNCH;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            FINISH: begin
                en_d = 1'b0;
                in_d = 1'b0;
                if (!terr_q) begin
                    sum_d = acc_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            base_q  <= 1'b0;
            en_q    <= 1'b0;
            in_q    <= 1'b0;
            terr_q  <= 1'b0;
            dly_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], chain_out};
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            en_q    <= en_d;
            in_q    <= in_d;
            terr_q  <= terr_d;
            dly_q   <= dly_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_chain_delay_meter.sv
// Directed bench for chain_delay_meter: a behavioural chain model with selectable delay,
// inversion, stuck and zero-delay modes, plus a narrow-counter instance for the no-wrap case.
module tb_chain_delay_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        chainEn, chainIn, chainOut;
    logic        busy, done, timeoutErr;
    logic [15:0] delayCycles;
    logic [17:0] delaySum;

    logic        start2 = 1'b0;
    logic        chainEn2, chainIn2;
    logic        chainOut2;
    logic        busy2, done2, timeoutErr2;
    logic [7:0]  delayCycles2;
    logic [9:0]  delaySum2;

    int          total = 0;
    int          bad = 0;
    int          doneCount = 0;

    int          dly = 10;
    logic        inv = 1'b0;
    logic        stuck = 1'b0;
    logic        stuckVal = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] sr = '0;

    always #5 clk = ~clk;

    always @(posedge clk) sr <= {sr[30:0], chainIn};
    always @(negedge clk) if (done) doneCount++;

    assign chainOut  = stuck ? stuckVal : ((zero ? chainIn : sr[dly-1]) ^ inv);
    assign chainOut2 = 1'b1;

    chain_delay_meter #(
        .CNT_W(16), .AVG_LOG2(2), .SYNC_STAGES(2), .SETTLE_CYCLES(64), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .chain_en(chainEn), .chain_in(chainIn), .chain_out(chainOut),
        .busy(busy), .done(done), .timeout_err(timeoutErr),
        .delay_cycles(delayCycles), .delay_sum(delaySum)
    );

    chain_delay_meter #(
        .CNT_W(8), .AVG_LOG2(2), .SYNC_STAGES(2), .SETTLE_CYCLES(64), .TIMEOUT_CYCLES(255)
    ) dutW (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .chain_en(chainEn2), .chain_in(chainIn2), .chain_out(chainOut2),
        .busy(busy2), .done(done2), .timeout_err(timeoutErr2),
        .delay_cycles(delayCycles2), .delay_sum(delaySum2)
    );

    // Pulses start, then waits (bounded) for done; reports whether busy ever dropped.
    task automatic runMeasure(input int maxCycles, output bit gotDone, output int busyLow);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        gotDone = 1'b0;
        busyLow = 0;
        cycles  = 0;
        while (!gotDone && cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            if (done) gotDone = 1'b1;
            else if (!busy) busyLow++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (chainEn !== 1'b0) begin bad++; $display("[TB] FAIL reset_chain_en got=%b want=0", chainEn); end
        total++; if (chainIn !== 1'b0) begin bad++; $display("[TB] FAIL reset_chain_in got=%b want=0", chainIn); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (timeoutErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b want=0", timeoutErr); end
        total++; if (delayCycles !== 16'd0) begin bad++; $display("[TB] FAIL reset_delay got=%0d want=0", delayCycles); end
        total++; if (delaySum !== 18'd0) begin bad++; $display("[TB] FAIL reset_sum got=%0d want=0", delaySum); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy2 got=%b want=0", busy2); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_same_polarity();
        bit gotDone;
        int busyLow;
        int doneBefore;
        dly = 10; inv = 1'b0; stuck = 1'b0; zero = 1'b0;
        doneBefore = doneCount;
        runMeasure(2000, gotDone, busyLow);
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL same_done got=%b want=1", gotDone); end
        total++; if (busyLow !== 0) begin bad++; $display("[TB] FAIL same_busy_low got=%0d want=0", busyLow); end
        @(negedge clk);
        total++; if (delayCycles !== 16'd12) begin bad++; $display("[TB] FAIL same_delay got=%0d want=12", delayCycles); end
        total++; if (delaySum !== 18'd48) begin bad++; $display("[TB] FAIL same_sum got=%0d want=48", delaySum); end
        total++; if (timeoutErr !== 1'b0) begin bad++; $display("[TB] FAIL same_timeout got=%b want=0", timeoutErr); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL same_busy_after got=%b want=0", busy); end
        total++; if (doneCount - doneBefore !== 1) begin bad++; $display("[TB] FAIL same_done_count got=%0d want=1", doneCount - doneBefore); end
    endtask

    task automatic test_timeout();
        bit gotDone;
        int busyLow;
        stuck = 1'b1; stuckVal = 1'b0;
        runMeasure(2000, gotDone, busyLow);
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL tmo_done got=%b want=1", gotDone); end
        @(negedge clk);
        total++; if (delayCycles !== 16'd100) begin bad++; $display("[TB] FAIL tmo_delay got=%0d want=100", delayCycles); end
        total++; if (timeoutErr !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err got=%b want=1", timeoutErr); end
        total++; if (delaySum !== 18'd48) begin bad++; $display("[TB] FAIL tmo_sum_kept got=%0d want=48", delaySum); end
        repeat (5) @(negedge clk);
        total++; if (timeoutErr !== 1'b1) begin bad++; $display("[TB] FAIL tmo_sticky got=%b want=1", timeoutErr); end
        stuck = 1'b0;
    endtask

    task automatic test_inverting();
        bit gotDone;
        int busyLow;
        dly = 5; inv = 1'b1; stuck = 1'b0; zero = 1'b0;
        repeat (4) @(negedge clk);
        runMeasure(2000, gotDone, busyLow);
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL inv_done got=%b want=1", gotDone); end
        @(negedge clk);
        total++; if (delayCycles !== 16'd7) begin bad++; $display("[TB] FAIL inv_delay got=%0d want=7", delayCycles); end
        total++; if (delaySum !== 18'd28) begin bad++; $display("[TB] FAIL inv_sum got=%0d want=28", delaySum); end
        total++; if (timeoutErr !== 1'b0) begin bad++; $display("[TB] FAIL inv_err_cleared got=%b want=0", timeoutErr); end
        inv = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit gotDone;
        int busyLow;
        int rises;
        int cycles;
        logic prevIn;
        dly = 10; inv = 1'b0; stuck = 1'b0; zero = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rises = 0; cycles = 0; prevIn = 1'b0;
        while (rises < 2 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (chainIn && !prevIn) rises++;
            prevIn = chainIn;
        end
        total++; if (rises !== 2) begin bad++; $display("[TB] FAIL mid_reach_sample2 got=%0d want=2", rises); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if ({chainEn, chainIn, busy, done, timeoutErr} !== 5'b0) begin bad++; $display("[TB] FAIL mid_ctrl got=%b want=00000", {chainEn, chainIn, busy, done, timeoutErr}); end
        total++; if (delayCycles !== 16'd0) begin bad++; $display("[TB] FAIL mid_delay got=%0d want=0", delayCycles); end
        total++; if (delaySum !== 18'd0) begin bad++; $display("[TB] FAIL mid_sum got=%0d want=0", delaySum); end
        repeat (20) @(negedge clk);
        runMeasure(2000, gotDone, busyLow);
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL mid_rerun_done got=%b want=1", gotDone); end
        @(negedge clk);
        total++; if (delayCycles !== 16'd12) begin bad++; $display("[TB] FAIL mid_rerun_delay got=%0d want=12", delayCycles); end
        total++; if (delaySum !== 18'd48) begin bad++; $display("[TB] FAIL mid_rerun_sum got=%0d want=48", delaySum); end
    endtask

    task automatic test_start_ignored();
        int doneBefore;
        int cycles;
        bit gotDone;
        dly = 10;
        doneBefore = doneCount;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        gotDone = 1'b0; cycles = 0;
        while (!gotDone && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (done) gotDone = 1'b1;
        end
        // Hold start across the edge on which FINISH exits.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL ign_done got=%b want=1", gotDone); end
        repeat (150) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ign_busy got=%b want=0", busy); end
        total++; if (doneCount - doneBefore !== 1) begin bad++; $display("[TB] FAIL ign_done_count got=%0d want=1", doneCount - doneBefore); end
        total++; if (delaySum !== 18'd48) begin bad++; $display("[TB] FAIL ign_sum got=%0d want=48", delaySum); end
    endtask

    task automatic test_zero_delay();
        bit gotDone;
        int busyLow;
        zero = 1'b1; inv = 1'b0; stuck = 1'b0;
        runMeasure(2000, gotDone, busyLow);
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL zero_done got=%b want=1", gotDone); end
        @(negedge clk);
        total++; if (delayCycles !== 16'd2) begin bad++; $display("[TB] FAIL zero_delay got=%0d want=2", delayCycles); end
        total++; if (delaySum !== 18'd8) begin bad++; $display("[TB] FAIL zero_sum got=%0d want=8", delaySum); end
        zero = 1'b0;
    endtask

    task automatic test_no_wrap();
        bit gotDone;
        int cycles;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        gotDone = 1'b0; cycles = 0;
        while (!gotDone && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (done2) gotDone = 1'b1;
        end
        total++; if (gotDone !== 1'b1) begin bad++; $display("[TB] FAIL wrap_done got=%b want=1", gotDone); end
        @(negedge clk);
        total++; if (delayCycles2 !== 8'hFF) begin bad++; $display("[TB] FAIL wrap_delay got=%0d want=255", delayCycles2); end
        total++; if (timeoutErr2 !== 1'b1) begin bad++; $display("[TB] FAIL wrap_err got=%b want=1", timeoutErr2); end
        total++; if (delaySum2 !== 10'd0) begin bad++; $display("[TB] FAIL wrap_sum got=%0d want=0", delaySum2); end
    endtask

    initial begin
        test_reset();
        test_same_polarity();
        test_timeout();
        test_inverting();
        test_reset_mid();
        test_start_ignored();
        test_zero_delay();
        test_no_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
